// File: rtl/trap_ctrl_pkg.sv
// Shared CSR map, bit positions, cause codes and FSM state for the machine-mode trap controller.
package trap_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CODE_W = 5;

  localparam logic [ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [ADDR_W-1:0] CSR_MIE      = 12'h304;
  localparam logic [ADDR_W-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [ADDR_W-1:0] CSR_MEPC     = 12'h341;
  localparam logic [ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [ADDR_W-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [ADDR_W-1:0] CSR_MIP      = 12'h344;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned IRQ_MSI_BIT = 3;
  localparam int unsigned IRQ_MTI_BIT = 7;
  localparam int unsigned IRQ_MEI_BIT = 11;

  localparam logic [CODE_W-1:0] CAUSE_MSI = 5'd3;
  localparam logic [CODE_W-1:0] CAUSE_MTI = 5'd7;
  localparam logic [CODE_W-1:0] CAUSE_MEI = 5'd11;

  localparam logic [DATA_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [1:0]        MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } trap_state_e;

  // MPP is hardwired to machine mode; only MIE/MPIE are live state.
  function automatic logic [DATA_W-1:0] mstatus_pack(input logic mie, input logic mpie);
    logic [DATA_W-1:0] v;
    v = '0;
    v[MSTATUS_MIE]    = mie;
    v[MSTATUS_MPIE]   = mpie;
    v[MSTATUS_MPP_LO] = 1'b1;
    v[MSTATUS_MPP_HI] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI, returns the mcause code of the winner.
module irq_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic              pend_mei,
  input  logic              pend_msi,
  input  logic              pend_mti,
  output logic              irq_valid_c,
  output logic [CODE_W-1:0] irq_code_c
);

  always_comb begin
    irq_valid_c = pend_mei | pend_msi | pend_mti;
    irq_code_c  = CAUSE_MTI;
    if (pend_mei) begin
      irq_code_c = CAUSE_MEI;
    end else if (pend_msi) begin
      irq_code_c = CAUSE_MSI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts exceptions, interrupts and mret, updates the trap CSRs,
// then sequences a pipeline flush followed by a single-cycle fetch redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  input  logic [CODE_W-1:0] exc_code,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [XLEN-1:0]   exc_tval,
  input  logic [XLEN-1:0]   resume_pc,
  input  logic              meip,
  input  logic              mtip,
  input  logic              msip,
  input  logic              mret_valid,
  input  logic              csr_we,
  input  logic [ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_wdata,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              flush_req,
  input  logic              flush_ack,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  trap_state_e       state;
  logic              mst_mie;
  logic              mst_mpie;
  logic [2:0]        mie_q;      // {MEIE, MTIE, MSIE}
  logic [XLEN-1:0]   mtvec_q;
  logic [XLEN-1:0]   mscratch_q;
  logic [XLEN-1:0]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtval_q;
  logic [XLEN-1:0]   trap_target_q;

  logic              irq_valid_c;
  logic [CODE_W-1:0] irq_code_c;
  logic              accept_exc_c;
  logic              accept_irq_c;
  logic              accept_mret_c;
  logic              accept_c;
  logic [XLEN-1:0]   mip_c;
  logic [XLEN-1:0]   mie_rd_c;
  logic [XLEN-1:0]   mtvec_base_c;
  logic [XLEN-1:0]   target_c;

  irq_prio_enc u_prio (
    .pend_mei    (mst_mie & mie_q[2] & meip),
    .pend_msi    (mst_mie & mie_q[0] & msip),
    .pend_mti    (mst_mie & mie_q[1] & mtip),
    .irq_valid_c (irq_valid_c),
    .irq_code_c  (irq_code_c)
  );

  // Event arbitration in IDLE: exception beats interrupt beats mret.
  always_comb begin
    accept_exc_c  = (state == ST_IDLE) && exc_valid;
    accept_irq_c  = (state == ST_IDLE) && !exc_valid && irq_valid_c;
    accept_mret_c = (state == ST_IDLE) && !exc_valid && !irq_valid_c && mret_valid;
    accept_c      = accept_exc_c | accept_irq_c | accept_mret_c;
  end

  // Redirect target, captured at acceptance so later mtvec/mepc writes cannot disturb it.
  always_comb begin
    mtvec_base_c = mtvec_q & PC_ALIGN_MASK;
    target_c     = mepc_q;
    if (exc_valid) begin
      target_c = mtvec_base_c;
    end else if (irq_valid_c) begin
      target_c = (mtvec_q[1:0] == MODE_VECTORED)
               ? mtvec_base_c + (XLEN'(irq_code_c) << 2)
               : mtvec_base_c;
    end
  end

  always_comb begin
    mip_c              = '0;
    mip_c[IRQ_MEI_BIT] = meip;
    mip_c[IRQ_MTI_BIT] = mtip;
    mip_c[IRQ_MSI_BIT] = msip;
    mie_rd_c              = '0;
    mie_rd_c[IRQ_MEI_BIT] = mie_q[2];
    mie_rd_c[IRQ_MTI_BIT] = mie_q[1];
    mie_rd_c[IRQ_MSI_BIT] = mie_q[0];
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_pack(mst_mie, mst_mpie);
      CSR_MIE:      csr_rdata = mie_rd_c;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = mip_c;
      default:      csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      flush_req      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
      mst_mie        <= 1'b0;
      mst_mpie       <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      trap_target_q  <= '0;
    end else begin
      // Trap/mret CSR side effects take precedence over a same-cycle software write.
      if (accept_exc_c || accept_irq_c) begin
        mepc_q   <= (accept_exc_c ? exc_pc : resume_pc) & PC_ALIGN_MASK;
        mcause_q <= accept_exc_c ? XLEN'(exc_code) : {1'b1, (XLEN-1)'(irq_code_c)};
        mtval_q  <= accept_exc_c ? exc_tval : '0;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (accept_mret_c) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mst_mie  <= csr_wdata[MSTATUS_MIE];
            mst_mpie <= csr_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= {csr_wdata[IRQ_MEI_BIT], csr_wdata[IRQ_MTI_BIT],
                                       csr_wdata[IRQ_MSI_BIT]};
          CSR_MTVEC:    mtvec_q    <= {csr_wdata[XLEN-1:2],
                                       csr_wdata[1] ? 2'b00 : csr_wdata[1:0]};
          CSR_MSCRATCH: mscratch_q <= csr_wdata;
          CSR_MEPC:     mepc_q     <= csr_wdata & PC_ALIGN_MASK;
          CSR_MCAUSE:   mcause_q   <= csr_wdata;
          CSR_MTVAL:    mtval_q    <= csr_wdata;
          default:      ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            state         <= ST_FLUSH;
            flush_req     <= 1'b1;
            busy          <= 1'b1;
            trap_target_q <= target_c;
          end
        end
        ST_FLUSH: begin
          if (flush_ack) begin
            state          <= ST_REDIRECT;
            flush_req      <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_target_q;
          end
        end
        ST_REDIRECT: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          flush_req      <= 1'b0;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: CSR WARL vector table plus hand-written trap/mret/reset sequences.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic [31:0] resume_pc;
  logic        meip, mtip, msip;
  logic        mret_valid;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        flush_req;
  logic        flush_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .resume_pc(resume_pc), .meip(meip), .mtip(mtip), .msip(msip),
    .mret_valid(mret_valid),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  // Entered at the negedge just after acceptance; ack is held off for ack_wait cycles.
  task automatic do_flush(input int ack_wait, input logic [31:0] exp_pc, input string tag);
    int pulses;
    check({tag, "_flush_req"}, 32'(flush_req), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      csr_we = 1'b0;
      check({tag, "_flush_hold"}, 32'({flush_req, redirect_valid}), 32'b10);
    end
    flush_ack = 1'b1;
    @(negedge clk);
    flush_ack = 1'b0;
    csr_we    = 1'b0;
    check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd1);
    check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (redirect_valid) pulses++;
    end
    check({tag, "_extra_pulses"}, 32'(pulses), 32'd0);
    check({tag, "_idle"}, 32'({busy, flush_req}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
    resume_pc = '0; meip = 1'b0; mtip = 1'b0; msip = 1'b0; mret_valid = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wdata = '0; flush_ack = 1'b0;

    vecs[0]  = '{CSR_MTVEC,    32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[1]  = '{CSR_MTVEC,    32'h0000_0102, 32'h0000_0100};
    vecs[2]  = '{CSR_MTVEC,    32'h0000_0101, 32'h0000_0101};
    vecs[3]  = '{CSR_MSTATUS,  32'hFFFF_FFFF, 32'h0000_1888};
    vecs[4]  = '{CSR_MSTATUS,  32'h0000_0000, 32'h0000_1800};
    vecs[5]  = '{CSR_MIE,      32'hFFFF_FFFF, 32'h0000_0888};
    vecs[6]  = '{CSR_MSCRATCH, 32'h1234_5678, 32'h1234_5678};
    vecs[7]  = '{CSR_MEPC,     32'h0000_0200, 32'h0000_0200};
    vecs[8]  = '{CSR_MCAUSE,   32'h0000_0005, 32'h0000_0005};
    vecs[9]  = '{CSR_MTVAL,    32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[10] = '{CSR_MIP,      32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{12'h7C0,      32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({flush_req, redirect_valid, busy}), 32'd0);
    csr_check("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    csr_check("rst_mtvec", CSR_MTVEC, 32'h0);
    csr_check("rst_mcause", CSR_MCAUSE, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // CSR write/readback table
    for (int i = 0; i < 12; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      csr_check($sformatf("csr_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Direct-mode exception with a delayed ack
    csr_write(CSR_MTVEC, 32'h100);
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
    @(negedge clk);
    exc_valid = 1'b0;
    do_flush(3, 32'h100, "exc");
    csr_check("exc_mepc", CSR_MEPC, 32'h80);
    csr_check("exc_mcause", CSR_MCAUSE, 32'h2);
    csr_check("exc_mtval", CSR_MTVAL, 32'hDEAD);

    // Vectored interrupt: MEI beats MTI, ack in first FLUSH cycle
    csr_write(CSR_MTVEC, 32'h101);
    csr_write(CSR_MSTATUS, 32'h8);
    csr_write(CSR_MIE, 32'h888);
    resume_pc = 32'h447; meip = 1'b1; mtip = 1'b1;
    @(negedge clk);
    meip = 1'b0; mtip = 1'b0;
    do_flush(0, 32'h12C, "mei");
    csr_check("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_check("mei_mepc", CSR_MEPC, 32'h444);
    csr_check("mei_mtval", CSR_MTVAL, 32'h0);
    csr_check("mei_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // MSI beats MTI
    csr_write(CSR_MSTATUS, 32'h8);
    msip = 1'b1; mtip = 1'b1;
    @(negedge clk);
    msip = 1'b0; mtip = 1'b0;
    do_flush(1, 32'h10C, "msi");
    csr_check("msi_mcause", CSR_MCAUSE, 32'h8000_0003);

    // Exception wins over pending interrupt and mret
    csr_write(CSR_MSTATUS, 32'h8);
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h300; exc_tval = 32'h11;
    msip = 1'b1; mret_valid = 1'b1;
    @(negedge clk);
    exc_valid = 1'b0; msip = 1'b0; mret_valid = 1'b0;
    do_flush(0, 32'h100, "prio");
    csr_check("prio_mcause", CSR_MCAUSE, 32'h5);
    csr_check("prio_mepc", CSR_MEPC, 32'h300);
    csr_check("prio_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // mret returns to mepc and restores MIE
    csr_write(CSR_MEPC, 32'h200);
    csr_write(CSR_MSTATUS, 32'h80);
    mret_valid = 1'b1;
    @(negedge clk);
    mret_valid = 1'b0;
    do_flush(0, 32'h200, "mret");
    csr_check("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    csr_check("mret_mcause", CSR_MCAUSE, 32'h5);
    csr_check("mret_mepc", CSR_MEPC, 32'h200);

    // Same-cycle CSR write dropped; mtvec write during FLUSH does not move the target
    csr_write(CSR_MSTATUS, 32'h0);
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h84; exc_tval = 32'h0;
    csr_we = 1'b1; csr_addr = CSR_MCAUSE; csr_wdata = 32'h5;
    @(negedge clk);
    exc_valid = 1'b0;
    csr_we = 1'b1; csr_addr = CSR_MTVEC; csr_wdata = 32'h300;
    do_flush(1, 32'h100, "drop");
    csr_check("drop_mcause", CSR_MCAUSE, 32'h2);
    csr_check("drop_mepc", CSR_MEPC, 32'h84);
    csr_check("drop_mtvec", CSR_MTVEC, 32'h300);

    // Reset pulse mid-FLUSH aborts the trap with no redirect
    exc_valid = 1'b1; exc_code = 5'd7; exc_pc = 32'h90;
    @(negedge clk);
    exc_valid = 1'b0;
    check("abort_flush_req", 32'(flush_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'({flush_req, redirect_valid, busy}), 32'd0);
    flush_ack = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      flush_ack = 1'b0;
      if (redirect_valid || busy) pulses++;
    end
    check("abort_no_redirect", 32'(pulses), 32'd0);
    csr_check("abort_mtvec", CSR_MTVEC, 32'h0);
    csr_check("abort_mcause", CSR_MCAUSE, 32'h0);
    csr_check("abort_mstatus", CSR_MSTATUS, 32'h0000_1800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
